// File: rtl/cla_adder_reg_if.sv
// Bundles the operand side and the registered result side of cla_adder_reg.
// The master drives operands and observes results; the adder core is the slave.
interface cla_adder_reg_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic             gp;
    logic             gg;
    logic             out_valid;

    modport master (
        output in_valid, a, b, cin,
        input  sum, cout, p, g, gp, gg, out_valid
    );

    modport slave (
        input  in_valid, a, b, cin,
        output sum, cout, p, g, gp, gg, out_valid
    );
endinterface

// File: rtl/cla_adder_reg.sv
// Registered two-level carry-lookahead adder built from 4-bit groups.
// Exposes per-bit and whole-word propagate/generate so a parent unit can cascade it.
module cla_adder_reg #(
    parameter int WIDTH = 4
) (
    input logic           clk,
    input logic           rst,
    cla_adder_reg_if.slave bus
);
    localparam int NG = WIDTH / 4;

    logic [WIDTH-1:0] pw;
    logic [WIDTH-1:0] gw;
    logic [WIDTH-1:0] sw;
    logic [WIDTH:0]   c;
    logic [NG-1:0]    grp_p;
    logic [NG-1:0]    grp_g;
    logic [NG:0]      gc;
    logic             word_gp;
    logic             word_gg;

    always_comb begin
        pw = bus.a ^ bus.b;
        gw = bus.a & bus.b;
    end

    // Group terms: walking down from bit 3, 'run' is the product of the p bits above.
    always_comb begin
        logic acc;
        logic run;
        acc   = 1'b0;
        run   = 1'b0;
        grp_p = '0;
        grp_g = '0;
        for (int k = 0; k < NG; k++) begin
            acc = 1'b0;
            run = 1'b1;
            for (int j = 3; j >= 0; j--) begin
                acc = acc | (gw[4*k+j] & run);
                run = run & pw[4*k+j];
            end
            grp_g[k] = acc;
            grp_p[k] = run;
        end
    end

    // Second level: every group carry is a flat sum of products over lower groups.
    always_comb begin
        logic acc;
        logic run;
        acc     = 1'b0;
        run     = 1'b0;
        gc      = '0;
        gc[0]   = bus.cin;
        word_gg = 1'b0;
        word_gp = &grp_p;
        for (int k = 0; k < NG; k++) begin
            acc = 1'b0;
            run = 1'b1;
            for (int j = k; j >= 0; j--) begin
                acc = acc | (grp_g[j] & run);
                run = run & grp_p[j];
            end
            gc[k+1] = acc | (run & bus.cin);
            if (k == NG - 1) begin
                word_gg = acc;
            end
        end
    end

    // Bit carries inside each group, expanded from that group's incoming carry.
    always_comb begin
        logic acc;
        logic run;
        acc = 1'b0;
        run = 1'b0;
        c   = '0;
        for (int k = 0; k < NG; k++) begin
            for (int i = 0; i < 4; i++) begin
                acc = 1'b0;
                run = 1'b1;
                for (int j = i - 1; j >= 0; j--) begin
                    acc = acc | (gw[4*k+j] & run);
                    run = run & pw[4*k+j];
                end
                c[4*k+i] = acc | (run & gc[k]);
            end
        end
        c[WIDTH] = gc[NG];
        sw       = pw ^ c[WIDTH-1:0];
    end

    // Results load only on valid input; out_valid tracks in_valid every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.sum       <= '0;
            bus.cout      <= 1'b0;
            bus.p         <= '0;
            bus.g         <= '0;
            bus.gp        <= 1'b0;
            bus.gg        <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.sum  <= sw;
                bus.cout <= c[WIDTH];
                bus.p    <= pw;
                bus.g    <= gw;
                bus.gp   <= word_gp;
                bus.gg   <= word_gg;
            end
        end
    end
endmodule

// File: tb/tb_cla_adder_reg.sv
// Drives a 4-bit and a 16-bit adder in lockstep; a monitor compares each result
// against an arithmetic reference queued when the operands were issued.
module tb_cla_adder_reg;
    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic [15:0] p;
        logic [15:0] g;
        logic        gp;
        logic        gg;
    } result_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cla_adder_reg_if #(.WIDTH(4))  bus4();
    cla_adder_reg_if #(.WIDTH(16)) bus16();

    cla_adder_reg #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4.slave));
    cla_adder_reg #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

    result_t q4[$];
    result_t q16[$];
    result_t held4;
    result_t held16;
    result_t zero_r;
    int checks = 0;
    int fails  = 0;

    function automatic result_t model(input int w, input logic [15:0] a,
                                      input logic [15:0] b, input logic cin);
        result_t r;
        longint unsigned mask, aa, bb, total;
        mask   = (64'd1 << w) - 64'd1;
        aa     = 64'(a) & mask;
        bb     = 64'(b) & mask;
        total  = aa + bb + 64'(cin);
        r.sum  = 16'(total & mask);
        r.cout = total[w];
        r.p    = 16'(aa ^ bb);
        r.g    = 16'(aa & bb);
        r.gp   = ((aa ^ bb) == mask);
        r.gg   = (((aa + bb) >> w) != 64'd0);
        return r;
    endfunction

    function automatic result_t sample4();
        result_t r;
        r.sum  = 16'(bus4.sum);
        r.cout = bus4.cout;
        r.p    = 16'(bus4.p);
        r.g    = 16'(bus4.g);
        r.gp   = bus4.gp;
        r.gg   = bus4.gg;
        return r;
    endfunction

    function automatic result_t sample16();
        result_t r;
        r.sum  = bus16.sum;
        r.cout = bus16.cout;
        r.p    = bus16.p;
        r.g    = bus16.g;
        r.gp   = bus16.gp;
        r.gg   = bus16.gg;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] required);
        checks++;
        if (actual !== required) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, required, $time);
        end
    endtask

    task automatic compareResult(input string tag, input result_t act, input result_t exp);
        checkOutput({tag, "_sum"},  act.sum,        exp.sum);
        checkOutput({tag, "_cout"}, 16'(act.cout),  16'(exp.cout));
        checkOutput({tag, "_p"},    act.p,          exp.p);
        checkOutput({tag, "_g"},    act.g,          exp.g);
        checkOutput({tag, "_gp"},   16'(act.gp),    16'(exp.gp));
        checkOutput({tag, "_gg"},   16'(act.gg),    16'(exp.gg));
    endtask

    // Drives one vector at posedge+2 and returns at posedge+2 after the capturing edge.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic valid);
        bus4.in_valid  = valid;
        bus4.a         = a[3:0];
        bus4.b         = b[3:0];
        bus4.cin       = cin;
        bus16.in_valid = valid;
        bus16.a        = a;
        bus16.b        = b;
        bus16.cin      = cin;
        if (valid && !rst) begin
            q4.push_back(model(4, a, b, cin));
            q16.push_back(model(16, a, b, cin));
        end
        @(posedge clk);
        #2;
    endtask

    // Monitor: one cycle after each edge, a valid output must match the oldest queued
    // expectation; an idle output must still show the last delivered result.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            q4.delete();
            q16.delete();
            held4  = '{default: '0};
            held16 = '{default: '0};
        end else begin
            if (bus4.out_valid) begin
                if (q4.size() == 0) begin
                    checkOutput("w4_unexpected_valid", 16'(bus4.out_valid), 16'd0);
                end else begin
                    held4 = q4.pop_front();
                    compareResult("w4", sample4(), held4);
                end
            end else begin
                compareResult("w4_hold", sample4(), held4);
            end
            checkOutput("w4_missing_valid", 16'(q4.size()), 16'd0);
            q4.delete();

            if (bus16.out_valid) begin
                if (q16.size() == 0) begin
                    checkOutput("w16_unexpected_valid", 16'(bus16.out_valid), 16'd0);
                end else begin
                    held16 = q16.pop_front();
                    compareResult("w16", sample16(), held16);
                end
            end else begin
                compareResult("w16_hold", sample16(), held16);
            end
            checkOutput("w16_missing_valid", 16'(q16.size()), 16'd0);
            q16.delete();
        end
    end

    initial begin
        zero_r = '{default: '0};
        rst    = 1'b1;
        bus4.in_valid  = 1'b0; bus4.a  = '0; bus4.b  = '0; bus4.cin  = 1'b0;
        bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        // Load nonzero results, then reset asynchronously between edges.
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        rst            = 1'b1;
        bus4.in_valid  = 1'b0;
        bus16.in_valid = 1'b0;
        #1;
        compareResult("rst_async4", sample4(), zero_r);
        compareResult("rst_async16", sample16(), zero_r);
        checkOutput("rst_async_ov4", 16'(bus4.out_valid), 16'd0);
        applyStimulus(16'h0009, 16'h0009, 1'b0, 1'b1);
        compareResult("rst_hold4", sample4(), zero_r);
        checkOutput("rst_hold_ov16", 16'(bus16.out_valid), 16'd0);
        rst = 1'b0;

        applyStimulus(16'd3, 16'd5, 1'b0, 1'b1);
        checkOutput("first_sum4", 16'(bus4.sum), 16'd8);
        checkOutput("first_p4", 16'(bus4.p), 16'b0110);
        checkOutput("first_g4", 16'(bus4.g), 16'b0001);
        checkOutput("first_ov4", 16'(bus4.out_valid), 16'd1);

        applyStimulus(16'h000F, 16'h0000, 1'b1, 1'b1);
        checkOutput("wrap_sum4", 16'(bus4.sum), 16'd0);
        checkOutput("wrap_cout4", 16'(bus4.cout), 16'd1);
        checkOutput("wrap_gp4", 16'(bus4.gp), 16'd1);
        checkOutput("wrap_gg4", 16'(bus4.gg), 16'd0);

        applyStimulus(16'h000F, 16'h000F, 1'b1, 1'b1);
        checkOutput("max_sum4", 16'(bus4.sum), 16'hF);
        checkOutput("max_g4", 16'(bus4.g), 16'hF);
        checkOutput("max_gp4", 16'(bus4.gp), 16'd0);
        checkOutput("max_gg4", 16'(bus4.gg), 16'd1);

        applyStimulus(16'd7, 16'd2, 1'b0, 1'b1);
        applyStimulus(16'd15, 16'd15, 1'b0, 1'b0);
        checkOutput("hold_sum4", 16'(bus4.sum), 16'd9);
        checkOutput("hold_ov4", 16'(bus4.out_valid), 16'd0);
        applyStimulus(16'd15, 16'd15, 1'b0, 1'b0);
        checkOutput("hold2_sum16", bus16.sum, 16'd9);

        applyStimulus(16'h00FF, 16'h0001, 1'b0, 1'b1);
        checkOutput("casc_sum16", bus16.sum, 16'h0100);
        checkOutput("casc_cout16", 16'(bus16.cout), 16'd0);
        applyStimulus(16'hFFFF, 16'h0000, 1'b1, 1'b1);
        checkOutput("casc2_sum16", bus16.sum, 16'h0000);
        checkOutput("casc2_cout16", 16'(bus16.cout), 16'd1);
        checkOutput("casc2_gp16", 16'(bus16.gp), 16'd1);

        for (int n = 0; n < 1000; n++) begin
            applyStimulus(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 9) != 0));
        end

        // A reset landing mid-stream discards the in-flight result.
        applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b1);
        rst            = 1'b1;
        bus4.in_valid  = 1'b0;
        bus16.in_valid = 1'b0;
        #1;
        compareResult("rst_mid16", sample16(), zero_r);
        applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b0);
        rst = 1'b0;
        applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b0);
        checkOutput("rst_mid_ov16", 16'(bus16.out_valid), 16'd0);

        for (int n = 0; n < 20; n++) begin
            applyStimulus(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1);
        end
        applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b0);
        applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
